// File: rtl/aq_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter between the download path and the Z80.
package aq_arb_pkg;

   localparam int SDRAM_AW = 25;
   localparam int DIO_AW   = 14;
   localparam int DATA_W   = 8;
   localparam int FIFO_W   = DIO_AW + DATA_W;

   localparam logic [SDRAM_AW-1:0] CART_BASE_DEF = 25'h00C000;
   localparam logic [1:0]          CART_REGION   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DIO  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/aq_arb_fifo.sv
// Download byte FIFO: {offset, data} entries, power-of-two depth, pointers wrap modulo depth.
module aq_arb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 22,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [PW:0]      o_count,
   output logic             o_drop
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [PW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);
   assign o_drop = i_push & ~w_push;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/aq_sdram_arbiter.sv
// Grants the single SDRAM port to the download FIFO or the Z80 external-memory path.
// Optional AQ_ARB_CART_WP_EN: CPU writes to the cartridge region are acknowledged but not forwarded.
//
// state | meaning
// IDLE  | arbitrate; issue the request for the granted requester
// CPU   | CPU transaction outstanding, wait for mem_ack
// DIO   | download write outstanding, wait for mem_ack
module aq_sdram_arbiter
   import aq_arb_pkg::*;
#(
   parameter int                  FIFO_DEPTH = 4,
   parameter logic [SDRAM_AW-1:0] CART_BASE  = CART_BASE_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_dio_wr,
   input  logic [DIO_AW-1:0]   i_dio_addr,
   input  logic [DATA_W-1:0]   i_dio_data,
   output logic                o_dio_full,
   output logic                o_dio_overflow,
   input  logic                i_cpu_req,
   input  logic                i_cpu_we,
   input  logic [15:0]         i_cpu_addr,
   input  logic [DATA_W-1:0]   i_cpu_din,
   output logic                o_cpu_ack,
   output logic [DATA_W-1:0]   o_cpu_q,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [SDRAM_AW-1:0] o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_din,
   input  logic                i_mem_ack,
   input  logic [DATA_W-1:0]   i_mem_q,
   output logic                o_busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   arb_state_t          r_state, w_state_nxt;
   logic                r_mem_req, w_mem_req_nxt;
   logic                r_mem_we, w_mem_we_nxt;
   logic [SDRAM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]   r_mem_din, w_mem_din_nxt;
   logic                r_cpu_ack, w_cpu_ack_nxt;
   logic [DATA_W-1:0]   r_cpu_q, w_cpu_q_nxt;
   logic                r_wp, w_wp_nxt;
   logic                r_overflow;

   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [CW-1:0]       w_fifo_count;
   logic                w_fifo_pop;
   logic                w_fifo_drop;
   logic [FIFO_W-1:0]   w_fifo_head;
   logic                w_wp_hit;

   aq_arb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (i_dio_wr),
      .i_wdata   ({i_dio_addr, i_dio_data}),
      .i_pop     (w_fifo_pop),
      .o_rdata   (w_fifo_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_count   (w_fifo_count),
      .o_drop    (w_fifo_drop)
   );

`ifdef AQ_ARB_CART_WP_EN
   assign w_wp_hit = i_cpu_we && (i_cpu_addr[15:14] == CART_REGION);
`else
   assign w_wp_hit = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_mem_req_nxt  = r_mem_req;
      w_mem_we_nxt   = r_mem_we;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_din_nxt  = r_mem_din;
      w_cpu_ack_nxt  = 1'b0;
      w_cpu_q_nxt    = r_cpu_q;
      w_wp_nxt       = r_wp;
      w_fifo_pop     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A full FIFO outranks the CPU so downloads cannot be starved into overflow.
            if (w_fifo_full || (!i_cpu_req && !w_fifo_empty)) begin
               w_state_nxt    = ST_DIO;
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b1;
               w_mem_addr_nxt = CART_BASE + SDRAM_AW'(w_fifo_head[FIFO_W-1:DATA_W]);
               w_mem_din_nxt  = w_fifo_head[DATA_W-1:0];
            end else if (i_cpu_req) begin
               w_state_nxt = ST_CPU;
               if (w_wp_hit) begin
                  w_wp_nxt = 1'b1;
               end else begin
                  w_mem_req_nxt  = 1'b1;
                  w_mem_we_nxt   = i_cpu_we;
                  w_mem_addr_nxt = {9'd0, i_cpu_addr};
                  w_mem_din_nxt  = i_cpu_din;
               end
            end
         end
         ST_CPU: begin
            if (r_wp) begin
               w_wp_nxt      = 1'b0;
               w_cpu_ack_nxt = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else if (i_mem_ack) begin
               w_mem_req_nxt = 1'b0;
               w_cpu_ack_nxt = 1'b1;
               if (!r_mem_we) begin
                  w_cpu_q_nxt = i_mem_q;
               end
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DIO: begin
            if (i_mem_ack) begin
               w_mem_req_nxt = 1'b0;
               w_fifo_pop    = 1'b1;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_mem_req_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state    <= ST_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_cpu_ack  <= 1'b0;
         r_cpu_q    <= 8'h00;
         r_wp       <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_din  <= w_mem_din_nxt;
         r_cpu_ack  <= w_cpu_ack_nxt;
         r_cpu_q    <= w_cpu_q_nxt;
         r_wp       <= w_wp_nxt;
         r_overflow <= r_overflow | w_fifo_drop;
      end
   end

   assign o_mem_req      = r_mem_req;
   assign o_mem_we       = r_mem_we;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_din      = r_mem_din;
   assign o_cpu_ack      = r_cpu_ack;
   assign o_cpu_q        = r_cpu_q;
   assign o_dio_full     = w_fifo_full;
   assign o_dio_overflow = r_overflow;
   assign o_busy         = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_aq_sdram_arbiter.sv
// Self-checking bench for aq_sdram_arbiter: CPU vector table, directed corner sequences, random run vs queue model.
module tb_aq_sdram_arbiter;

   localparam int          DEPTH = 4;
   localparam logic [24:0] BASE  = 25'h00C000;
`ifdef AQ_ARB_CART_WP_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        dio_wr;
   logic [13:0] dio_addr;
   logic [7:0]  dio_data;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        mem_ack;
   logic [7:0]  mem_q;
   logic        o_dio_full, o_dio_overflow, o_cpu_ack, o_mem_req, o_mem_we, o_busy;
   logic [7:0]  o_cpu_q, o_mem_din;
   logic [24:0] o_mem_addr;

   int n_checks = 0;
   int n_err    = 0;

   aq_sdram_arbiter #(.FIFO_DEPTH(DEPTH), .CART_BASE(BASE)) dut (
      .i_clk(clk), .i_reset_n(reset_n),
      .i_dio_wr(dio_wr), .i_dio_addr(dio_addr), .i_dio_data(dio_data),
      .o_dio_full(o_dio_full), .o_dio_overflow(o_dio_overflow),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
      .o_cpu_ack(o_cpu_ack), .o_cpu_q(o_cpu_q),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
      .i_mem_ack(mem_ack), .i_mem_q(mem_q), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [46:0] outs();
      return {o_mem_req, o_mem_we, o_mem_addr, o_mem_din, o_cpu_ack, o_cpu_q,
              o_dio_full, o_dio_overflow, o_busy};
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   // ---------------- CPU vector table ----------------
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  din;
      int          lat;
      logic [7:0]  q;
      logic [24:0] exp_addr;
      logic [7:0]  exp_q;
   } cpu_vec_t;

   cpu_vec_t vecs[6];

   task automatic do_cpu(input cpu_vec_t v, input int idx);
      bit wp;
      wp = WP_EN && v.we && (v.addr[15:14] == 2'b11);
      cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din; cpu_req = 1'b1;
      step();
      if (wp) begin
         check($sformatf("v%0d wp mem_req", idx), o_mem_req, 1'b0);
         step();
         check($sformatf("v%0d wp ack/req", idx), {o_cpu_ack, o_mem_req}, 2'b10);
         cpu_req = 1'b0;
      end else begin
         check($sformatf("v%0d grant req/we", idx), {o_mem_req, o_mem_we}, {1'b1, v.we});
         check($sformatf("v%0d mem_addr", idx), o_mem_addr, v.exp_addr);
         if (v.we) check($sformatf("v%0d mem_din", idx), o_mem_din, v.din);
         for (int i = 1; i < v.lat; i++) begin
            step();
            check($sformatf("v%0d wait req/ack", idx), {o_mem_req, o_cpu_ack, o_busy}, 3'b101);
         end
         mem_ack = 1'b1; mem_q = v.q;
         step();
         mem_ack = 1'b0; mem_q = 8'hEE;
         check($sformatf("v%0d done ack/req", idx), {o_cpu_ack, o_mem_req}, 2'b10);
         cpu_req = 1'b0;
      end
      check($sformatf("v%0d cpu_q", idx), o_cpu_q, v.exp_q);
      step();
      check($sformatf("v%0d after ack/busy", idx), {o_cpu_ack, o_busy}, 2'b00);
   endtask

   task automatic mem_serve(input int lat, output logic [24:0] a, output logic [7:0] d,
                            output logic we, output bit ok);
      int t = 0;
      while (!o_mem_req && t < 50) begin
         step();
         t++;
      end
      ok = o_mem_req; a = o_mem_addr; d = o_mem_din; we = o_mem_we;
      if (!ok) return;
      for (int i = 1; i < lat; i++) step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [21:0] mq[$];
   int          m_owner;   // 0 none, 1 cpu, 2 download
   logic        m_req, m_we, m_ack, m_ovf;
   logic [24:0] m_addr;
   logic [7:0]  m_din, m_q;

   function automatic void model_reset();
      mq.delete();
      m_owner = 0; m_req = 0; m_we = 0; m_ack = 0; m_ovf = 0;
      m_addr = '0; m_din = '0; m_q = '0;
   endfunction

   function automatic void model_edge();
      bit pop = 0;
      m_ack = 0;
      if (m_owner == 0) begin
         if (mq.size() == DEPTH || (!cpu_req && mq.size() > 0)) begin
            m_owner = 2; m_req = 1; m_we = 1;
            m_addr = BASE + {11'd0, mq[0][21:8]};
            m_din  = mq[0][7:0];
         end else if (cpu_req) begin
            m_owner = 1; m_req = 1; m_we = cpu_we;
            m_addr = {9'd0, cpu_addr}; m_din = cpu_din;
         end
      end else if (mem_ack) begin
         if (m_owner == 1) begin
            m_ack = 1;
            if (!m_we) m_q = mem_q;
         end else begin
            pop = 1;
         end
         m_req = 0; m_owner = 0;
      end
      if (pop) void'(mq.pop_front());
      if (dio_wr) begin
         if (mq.size() < DEPTH) mq.push_back({dio_addr, dio_data});
         else m_ovf = 1;
      end
   endfunction

   function automatic logic [46:0] model_outs();
      return {m_req, m_we, m_addr, m_din, m_ack, m_q, (mq.size() == DEPTH), m_ovf,
              (m_owner != 0 || mq.size() != 0)};
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [24:0] a;
      logic [7:0]  d;
      logic        we;
      bit          ok;
      bit          saw;
      int          wait_cnt;

      vecs[0] = '{1'b0, 16'h3900, 8'h00, 3, 8'hA5, 25'h003900, 8'hA5};
      vecs[1] = '{1'b1, 16'h1234, 8'h5A, 1, 8'h77, 25'h001234, 8'hA5};
      vecs[2] = '{1'b0, 16'hFFFF, 8'h00, 1, 8'h3C, 25'h00FFFF, 8'h3C};
      vecs[3] = '{1'b1, 16'hC010, 8'h99, 2, 8'h11, 25'h00C010, 8'h3C};
      vecs[4] = '{1'b0, 16'hC010, 8'h00, 4, 8'hE1, 25'h00C010, 8'hE1};
      vecs[5] = '{1'b0, 16'h0000, 8'h00, 2, 8'h00, 25'h000000, 8'h00};

      reset_n = 1'b0; dio_wr = 0; dio_addr = '0; dio_data = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0; mem_ack = 0; mem_q = 8'hEE;
      step(); step(); step();
      check("reset outputs", outs(), 47'd0);
      reset_n = 1'b1;
      step();
      check("idle outputs", outs(), 47'd0);

      for (int i = 0; i < 6; i++) do_cpu(vecs[i], i);

      // CPU drops request after the grant: transaction still completes and acks.
      cpu_we = 0; cpu_addr = 16'h0042; cpu_req = 1;
      step();
      cpu_req = 0;
      step(); step();
      mem_ack = 1; mem_q = 8'h6B;
      step();
      mem_ack = 0; mem_q = 8'hEE;
      check("drop-req ack/q", {o_cpu_ack, o_cpu_q}, {1'b1, 8'h6B});
      step();
      check("drop-req ack low", o_cpu_ack, 1'b0);

      // Download burst with ack withheld, then an overflowing fifth push.
      for (int i = 0; i < 4; i++) begin
         dio_wr = 1; dio_addr = 14'(i); dio_data = 8'(8'h10 + i);
         step();
         check($sformatf("burst full after push %0d", i), o_dio_full, (i == 3));
      end
      dio_wr = 0;
      check("burst overflow", o_dio_overflow, 1'b0);
      dio_wr = 1; dio_addr = 14'd4; dio_data = 8'h14;
      step();
      dio_wr = 0;
      check("overflow set", {o_dio_overflow, o_dio_full}, 2'b11);
      step(); step();
      check("overflow sticky", o_dio_overflow, 1'b1);
      for (int k = 0; k < 4; k++) begin
         mem_serve(2, a, d, we, ok);
         check($sformatf("burst %0d granted", k), ok, 1'b1);
         check($sformatf("burst %0d addr/din/we", k), {a, d, we}, {BASE + 25'(k), 8'(8'h10 + k), 1'b1});
      end
      saw = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (o_mem_req) saw = 1;
      end
      check("no fifth write", saw, 1'b0);
      check("drained busy/ovf", {o_busy, o_dio_overflow}, 2'b01);
      do_reset();
      check("reset clears overflow", o_dio_overflow, 1'b0);

      // Contention: one queued byte versus a CPU request -> CPU first.
      dio_wr = 1; dio_addr = 14'h0020; dio_data = 8'hC1;
      step();
      dio_wr = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_din = 8'h55;
      step();
      check("cont1 cpu first", {o_mem_req, o_mem_we, o_mem_addr, o_mem_din}, {2'b11, 25'h000100, 8'h55});
      mem_ack = 1;
      step();
      mem_ack = 0;
      check("cont1 cpu ack", o_cpu_ack, 1'b1);
      cpu_req = 0;
      mem_serve(1, a, d, we, ok);
      check("cont1 dio next", {ok, a, d, we}, {1'b1, 25'h00C020, 8'hC1, 1'b1});

      // Contention: full FIFO versus a CPU request -> download first.
      for (int i = 0; i < 4; i++) begin
         dio_wr = 1; dio_addr = 14'(14'h100 + i); dio_data = 8'(8'h80 + i);
         step();
      end
      check("cont2 head in flight", {o_mem_req, o_mem_addr, o_dio_full}, {1'b1, 25'h00C100, 1'b1});
      dio_wr = 1; dio_addr = 14'h104; dio_data = 8'h84;
      mem_ack = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2222;
      step();
      dio_wr = 0; mem_ack = 0;
      check("cont2 push+pop full", {o_dio_full, o_mem_req, o_dio_overflow}, 3'b100);
      step();
      check("cont2 dio first", {o_mem_req, o_mem_we, o_mem_addr}, {2'b11, 25'h00C101});
      mem_ack = 1;
      step();
      mem_ack = 0;
      step();
      check("cont2 cpu next", {o_mem_req, o_mem_we, o_mem_addr}, {2'b10, 25'h002222});
      mem_ack = 1; mem_q = 8'h3D;
      step();
      mem_ack = 0; mem_q = 8'hEE;
      check("cont2 cpu ack/q", {o_cpu_ack, o_cpu_q}, {1'b1, 8'h3D});
      cpu_req = 0;
      for (int k = 2; k < 5; k++) begin
         mem_serve(1, a, d, we, ok);
         check($sformatf("cont2 drain %0d", k), {ok, a, d}, {1'b1, 25'h00C100 + 25'(k), 8'(8'h80 + k)});
      end

      // Reset in the middle of a CPU transaction; a late ack must be ignored.
      step();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0777;
      step();
      check("mid-rst req", o_mem_req, 1'b1);
      reset_n = 0;
      step();
      check("mid-rst outputs", outs(), 47'd0);
      reset_n = 1; cpu_req = 0;
      step();
      mem_ack = 1; mem_q = 8'h99;
      step();
      mem_ack = 0; mem_q = 8'hEE;
      check("late ack ignored", {o_cpu_ack, o_mem_req, o_cpu_q}, 10'd0);
      step();
      check("late ack none", o_cpu_ack, 1'b0);

      // Randomized run against the queue model.
      do_reset();
      model_reset();
      wait_cnt = int'($urandom_range(0, 3));
      for (int c = 0; c < 3000; c++) begin
         mem_ack = 0;
         mem_q = 8'($urandom);
         if (o_mem_req) begin
            if (wait_cnt == 0) begin
               mem_ack = 1;
               wait_cnt = int'($urandom_range(0, 3));
            end else begin
               wait_cnt--;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            mem_ack = 1;
         end
         if (cpu_req && o_cpu_ack) begin
            cpu_req = 0;
         end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
            cpu_req = 1;
            cpu_we = 1'($urandom);
            cpu_addr = 16'($urandom);
            if (WP_EN) cpu_addr[15] = 1'b0;
            cpu_din = 8'($urandom);
         end
         dio_wr = ($urandom_range(0, 2) == 0);
         dio_addr = 14'($urandom);
         dio_data = 8'($urandom);
         @(posedge clk);
         model_edge();
         #1;
         check($sformatf("rand cycle %0d", c), outs(), model_outs());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
